// File: rtl/branch_target_predictor.sv
// Tagged BTB + 2-bit counter predictor with optional gshare history; tables cleared by a post-reset sweep.
// Latency: lookup result registered, valid the cycle after pred_oe; training applied on the fb_we edge.
// Backpressure: none; busy is high during the init sweep, and lookups/training are ignored while it is high. Optional counters: BP_STATS_EN.
module branch_target_predictor #(
  parameter int XLEN      = 32,
  parameter int SCALE     = 10,
  parameter int TAG_WIDTH = 8,
  parameter int GHR_WIDTH = 8,
  parameter int CTR_INIT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_oe,
  input  logic [XLEN-1:0]      pred_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  output logic [GHR_WIDTH+1:0] pred_meta,
  input  logic                 fb_we,
  input  logic [XLEN-1:0]      fb_pc,
  input  logic                 fb_taken,
  input  logic [XLEN-1:0]      fb_target,
  input  logic [GHR_WIDTH+1:0] fb_meta,
  input  logic                 fb_mispredict,
  output logic                 busy,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_mispredicts
);

  localparam int DEPTH = 1 << SCALE;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [SCALE-1:0] sweep_ptr;
  logic             run;

  // Tables: BTB (valid/tag/target) indexed by PC, counters indexed by PC ^ history.
  logic                 tbl_valid  [DEPTH];
  logic [TAG_WIDTH-1:0] tbl_tag    [DEPTH];
  logic [XLEN-1:0]      tbl_target [DEPTH];
  logic [1:0]           tbl_ctr    [DEPTH];

  logic [SCALE-1:0]     ghr_idx;      // live history, zero-extended to index width
  logic [SCALE-1:0]     fb_ghr_idx;   // history snapshot carried with the trained branch
  logic [GHR_WIDTH+1:0] lookup_meta;

  logic [SCALE-1:0]     lk_idx, lk_ctr_idx;
  logic [TAG_WIDTH-1:0] lk_tag;
  logic [1:0]           lk_ctr;
  logic                 lk_hit;

  logic [SCALE-1:0]     fb_idx, fb_ctr_idx;
  logic [1:0]           fb_ctr_old, fb_ctr_wr;

  logic                 unused_bits;

  assign run = (state_q == RUN);

  // State register and sweep pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT;
      sweep_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) sweep_ptr <= sweep_ptr + 1'b1;
    end
  end

  // Leave INIT on the edge that clears the last entry; busy tracks INIT.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      INIT: begin
        busy = 1'b1;
        if (sweep_ptr == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  generate
    if (GHR_WIDTH > 0) begin : g_ghr
      logic [GHR_WIDTH-1:0] ghr_q;

      // Committed global history: shift in each resolved direction.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ghr_q <= '0;
        else if (run && fb_we) ghr_q <= (ghr_q << 1) | GHR_WIDTH'(fb_taken);
      end

      assign ghr_idx     = SCALE'(ghr_q);
      assign fb_ghr_idx  = SCALE'(fb_meta[GHR_WIDTH+1:2]);
      assign lookup_meta = {ghr_q, lk_ctr};
    end else begin : g_bimodal
      assign ghr_idx     = '0;
      assign fb_ghr_idx  = '0;
      assign lookup_meta = lk_ctr;
    end
  endgenerate

  assign lk_idx     = pred_pc[2 +: SCALE];
  assign lk_tag     = pred_pc[2+SCALE +: TAG_WIDTH];
  assign lk_ctr_idx = lk_idx ^ ghr_idx;
  assign lk_ctr     = tbl_ctr[lk_ctr_idx];
  assign lk_hit     = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

  assign fb_idx     = fb_pc[2 +: SCALE];
  assign fb_ctr_idx = fb_idx ^ fb_ghr_idx;
  assign fb_ctr_old = fb_meta[1:0];

  // Saturating update of the counter value seen at lookup time.
  always_comb begin
    fb_ctr_wr = fb_ctr_old;
    if (fb_taken) begin
      if (fb_ctr_old != 2'd3) fb_ctr_wr = fb_ctr_old + 2'd1;
    end else if (fb_ctr_old != 2'd0) begin
      fb_ctr_wr = fb_ctr_old - 2'd1;
    end
  end

  // Table writes: sweep clears one entry per cycle in INIT, training writes in RUN.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      tbl_valid[sweep_ptr] <= 1'b0;
      tbl_ctr[sweep_ptr]   <= 2'(CTR_INIT);
    end else if (fb_we) begin
      tbl_ctr[fb_ctr_idx] <= fb_ctr_wr;
      if (fb_taken) begin
        tbl_valid[fb_idx]  <= 1'b1;
        tbl_tag[fb_idx]    <= fb_pc[2+SCALE +: TAG_WIDTH];
        tbl_target[fb_idx] <= {fb_target[XLEN-1:1], 1'b0};
      end
    end
  end

  // Registered lookup result; holds when pred_oe is low or during the sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      pred_meta   <= '0;
    end else if (run && pred_oe) begin
      pred_hit    <= lk_hit;
      pred_taken  <= lk_hit & lk_ctr[1];
      pred_target <= lk_hit ? tbl_target[lk_idx] : '0;
      pred_meta   <= lookup_meta;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, mispred_q;

  // Event counters; stay at zero through the sweep, wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else if (run) begin
      if (pred_oe)                lookups_q <= lookups_q + 32'd1;
      if (fb_we && fb_mispredict) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispred_q;
`else
  assign stat_lookups     = '0;
  assign stat_mispredicts = '0;
`endif

  // PC low bits, bits above the tag and target[0] carry no information here.
  assign unused_bits = ^{pred_pc, fb_pc, fb_target[0], fb_mispredict};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor (SCALE=4, TAG_WIDTH=8, GHR_WIDTH=2, CTR_INIT=1).
// Directed scenarios followed by randomized traffic, checked against a table-level model.
// Stats expectations follow BP_STATS_EN when it is defined, zero otherwise.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pred_oe = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [3:0]  pred_meta;
  logic        fb_we = 1'b0;
  logic [31:0] fb_pc = '0;
  logic        fb_taken = 1'b0;
  logic [31:0] fb_target = '0;
  logic [3:0]  fb_meta = '0;
  logic        fb_mispredict = 1'b0;
  logic        busy;
  logic [31:0] stat_lookups, stat_mispredicts;

  branch_target_predictor #(
    .XLEN(32), .SCALE(4), .TAG_WIDTH(8), .GHR_WIDTH(2), .CTR_INIT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_oe(pred_oe), .pred_pc(pred_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_meta(pred_meta),
    .fb_we(fb_we), .fb_pc(fb_pc), .fb_taken(fb_taken),
    .fb_target(fb_target), .fb_meta(fb_meta), .fb_mispredict(fb_mispredict),
    .busy(busy), .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain arrays indexed by table entry.
  int          m_valid [16];
  int          m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  int          m_ghr;
  int          m_init_left;
  int          e_hit, e_taken, e_meta;
  logic [31:0] e_tgt;
  int unsigned e_lk, e_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = '0;
    end
    m_ghr = 0; m_init_left = 16;
    e_hit = 0; e_taken = 0; e_meta = 0; e_tgt = '0;
    e_lk = 0; e_mis = 0;
  endtask

  task automatic model_edge();
    int idx, tag, ci, fi, c, g;
    if (m_init_left > 0) begin
      m_init_left--;
      return;
    end
    if (pred_oe) begin
      idx = int'((pred_pc / 4) % 16);
      tag = int'((pred_pc / 64) % 256);
      ci  = idx ^ m_ghr;
      e_hit   = (m_valid[idx] == 1 && m_tag[idx] == tag) ? 1 : 0;
      e_taken = (e_hit == 1 && m_ctr[ci] >= 2) ? 1 : 0;
      e_tgt   = (e_hit == 1) ? m_tgt[idx] : 32'd0;
      e_meta  = m_ghr * 4 + m_ctr[ci];
      e_lk++;
    end
    if (fb_we) begin
      fi = int'((fb_pc / 4) % 16);
      c  = int'(fb_meta % 4);
      g  = int'(fb_meta / 4);
      if (fb_taken) begin
        m_ctr[fi ^ g] = (c == 3) ? 3 : c + 1;
        m_valid[fi]   = 1;
        m_tag[fi]     = int'((fb_pc / 64) % 256);
        m_tgt[fi]     = fb_target - (fb_target % 2);
      end else begin
        m_ctr[fi ^ g] = (c == 0) ? 0 : c - 1;
      end
      m_ghr = (m_ghr * 2 + (fb_taken ? 1 : 0)) % 4;
      if (fb_mispredict) e_mis++;
    end
  endtask

  task automatic check_all();
    check("busy",        32'(busy),       (m_init_left > 0) ? 32'd1 : 32'd0);
    check("pred_hit",    32'(pred_hit),   32'(e_hit));
    check("pred_taken",  32'(pred_taken), 32'(e_taken));
    check("pred_target", pred_target,     e_tgt);
    check("pred_meta",   32'(pred_meta),  32'(e_meta));
`ifdef BP_STATS_EN
    check("stat_lookups",     stat_lookups,     e_lk);
    check("stat_mispredicts", stat_mispredicts, e_mis);
`else
    check("stat_lookups",     stat_lookups,     32'd0);
    check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
  endtask

  task automatic step(input logic oe, input logic [31:0] pc, input logic we,
                      input logic [31:0] fpc, input logic tk, input logic [31:0] tgt,
                      input logic [3:0] meta, input logic mis);
    pred_oe = oe; pred_pc = pc;
    fb_we = we; fb_pc = fpc; fb_taken = tk; fb_target = tgt;
    fb_meta = meta; fb_mispredict = mis;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [3:0] meta, input logic mis);
    step(1'b0, 32'd0, 1'b1, pc, tk, tgt, meta, mis);
  endtask

  // Asynchronous reset entry is checked before any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    r[13:6] = 8'($urandom_range(0, 2));
    return r;
  endfunction

  initial begin
    int cycles;
    #3;
    do_reset();

    // Sweep length, with lookups offered while busy.
    cycles = 0;
    while (busy && cycles < 40) begin
      lookup(32'h40);
      cycles++;
    end
    check("busy_cycles", 32'(cycles), 32'd16);

    // First lookup after the sweep reports the initial counter.
    lookup(32'h40);
    check("first_meta", 32'(pred_meta), 32'h1);

    // Train 0x40 taken, then two not-taken elsewhere to bring history back to 00.
    train(32'h40, 1'b1, 32'h101, 4'b0001, 1'b0);
    train(32'h4C, 1'b0, 32'h0,   4'b0001, 1'b0);
    train(32'h4C, 1'b0, 32'h0,   4'b0001, 1'b0);
    lookup(32'h40);
    check("train_hit",    32'(pred_hit),   32'd1);
    check("train_taken",  32'(pred_taken), 32'd1);
    check("train_target", pred_target,     32'h100);
    check("train_meta",   32'(pred_meta),  32'h2);

    // Same index, different tag.
    lookup(32'h440);
    check("alias_hit",    32'(pred_hit),  32'd0);
    check("alias_target", pred_target,    32'd0);

    // Saturate up at 3, then down at 0, on counter entry 0.
    train(32'h40, 1'b1, 32'h101, 4'b0010, 1'b0);
    train(32'h40, 1'b1, 32'h101, 4'b0011, 1'b0);
    train(32'h40, 1'b1, 32'h101, 4'b0011, 1'b0);
    train(32'h40, 1'b1, 32'h101, 4'b0011, 1'b0);
    lookup(32'h4C);
    check("sat_hi_meta", 32'(pred_meta), 32'hF);
    train(32'h40, 1'b0, 32'h0, 4'b0011, 1'b0);
    train(32'h40, 1'b0, 32'h0, 4'b0010, 1'b0);
    train(32'h40, 1'b0, 32'h0, 4'b0001, 1'b0);
    train(32'h40, 1'b0, 32'h0, 4'b0000, 1'b0);
    lookup(32'h40);
    check("sat_lo_meta",  32'(pred_meta),  32'h0);
    check("sat_lo_taken", 32'(pred_taken), 32'd0);
    check("sat_lo_hit",   32'(pred_hit),   32'd1);

    // History 10 steers the 0x40 lookup to counter entry 2.
    train(32'h4C, 1'b1, 32'h200, 4'b0000, 1'b0);
    train(32'h4C, 1'b0, 32'h0,   4'b0000, 1'b0);
    lookup(32'h40);
    check("gshare_meta", 32'(pred_meta), 32'h9);

    // Lookup and training of the same entry on one edge: old counter returned.
    step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h101, 4'b1001, 1'b0);
    check("collide_meta", 32'(pred_meta), 32'h9);

    for (int i = 0; i < 3; i++) train(32'h50, 1'b0, 32'h0, 4'b0000, 1'b1);
    lookup(32'h40);

    // Reset mid-run clears history and counters.
    do_reset();
    check("rst_lookups", stat_lookups,     32'd0);
    check("rst_mispred", stat_mispredicts, 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 2) != 0),
             rand_pc(), 1'($urandom_range(0, 1)), $urandom,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
